// File: rtl/prio_req_scheduler.sv
// Clocked priority/round-robin request scheduler with sticky pending bits and a valid/ready grant output.
// Optional per-source masking is enabled by defining PRIO_REQ_SCHEDULER_MASK_EN.
module prio_req_scheduler #(
  parameter int N  = 8,
  parameter bit RR = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
`ifdef PRIO_REQ_SCHEDULER_MASK_EN
  input  logic [N-1:0]         mask_i,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_code,
  output logic [N-1:0]         pending_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  pending;
  logic [N-1:0]  cand;
  logic [N-1:0]  rot;
  logic [N-1:0]  clr;
  logic [CW-1:0] last;
  logic [CW-1:0] pick;
  logic          found;
  logic          load;
  int            base;
  int            off;
  int            pos;

`ifdef PRIO_REQ_SCHEDULER_MASK_EN
  assign cand = pending & ~mask_i;
`else
  assign cand = pending;
`endif

  assign load = !out_valid || out_ready;

  // Rotate candidates so the search always starts at bit 0, then un-rotate the winner.
  always_comb begin
    base  = RR ? (int'(last) + 1) % N : 0;
    rot   = N'({cand, cand} >> base);
    found = |cand;
    off   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    pos  = (base + off) % N;
    pick = CW'(pos);
    clr  = '0;
    if (load && found) clr = {{(N-1){1'b0}}, 1'b1} << pos;
  end

  // A request on the same edge as its grant survives because the set is OR-ed in last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      last      <= CW'(N - 1);
    end else begin
      pending <= (pending & ~clr) | req_i;
      if (load) begin
        if (found) begin
          out_valid <= 1'b1;
          out_code  <= pick;
          last      <= pick;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign pending_o = pending;
  assign busy_o    = out_valid | (|pending);

endmodule

// File: doc/prio_req_scheduler.md
Name: prio_req_scheduler

Overview:
- Parametrised, clocked successor to the team's 8-input combinational priority encoder.
- Captures request pulses from N sources into a sticky pending register.
- Issues one encoded source index per grant over a valid/ready handshake.
- Supports two arbitration modes: fixed lowest-index-first (same priority order as the combinational encoder) and round-robin. Sits between interrupt/event sources and a single serial consumer, e.g. a service FSM or a register-read port.

Parameters:
- N, 8, number of request sources; legal range 2..64.
- RR, 0, 0 = fixed priority (index 0 highest); 1 = round-robin starting after the last granted index.
- CW, $clog2(N), derived localparam, width of out_code; never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; asserts immediately, release is synchronous to clk
- req_i  input  N  request pulses or levels, one bit per source; sampled every edge
- out_valid  output  1  out_code holds a granted source index
- out_ready  input  1  consumer accepts out_code this cycle
- out_code  output  CW  granted source index, 0..N-1
- pending_o  output  N  current sticky pending register, for status reads
- busy_o  output  1  high when out_valid is high or any pending bit is set

Behaviour:
- Reset (rst_n low, asynchronous):
  - pending = 0, out_valid = 0, out_code = 0, busy_o = 0.
  - Round-robin pointer last = N-1, so the first search starts at index 0.
  - Asserting reset mid-handshake discards the grant and all pending bits; nothing is replayed after release.
- Output state: two implicit states.
  - EMPTY: out_valid = 0.
  - HOLD: out_valid = 1.
- Load condition: load = !out_valid || out_ready.
- On each edge with load:
  - If pending has any bit set: pick index k, out_valid <= 1, out_code <= k, clear pending[k], last <= k.
  - Otherwise out_valid <= 0 and out_code keeps its old value.
- Handshake stability: while out_valid && !out_ready, out_code and out_valid hold stable and pending[k] for the held grant is already clear.
- Back-to-back transfers: when out_ready is held high, one grant per cycle, no bubbles, while pending is non-zero.
- Pending update every edge: pending <= (pending & ~clr) | req_i.
  - clr is the one-hot of k when loading, else 0.
  - If req_i[k] is high on the same edge k is granted, the set wins: pending[k] stays 1 and counts as a re-request.
- Request coalescing: multiple pulses on one source before its grant merge into a single grant. This is intended; no counting.
- Selection is made from the registered pending only; req_i does not bypass it.
- Latency:
  - req_i pulse sampled at edge e sets pending at e.
  - out_valid rises at edge e+1 if the output is EMPTY or being accepted; 2 edges minimum from request to visible grant.
- Fixed mode (RR=0): k = lowest set index of pending.
- Round-robin mode (RR=1):
  - k = first set index scanning last+1, last+2, …, wrapping N-1 to 0, ending at last.
  - last is inclusive as the final candidate, so a lone repeated requester is still served every cycle.
- Non-power-of-two N: out_code only ever takes values 0..N-1.
- busy_o = out_valid | (|pending); combinational from registers.
- No glitches: all outputs except busy_o come straight from flops.

Optional Feature:
- Macro: PRIO_REQ_SCHEDULER_MASK_EN.
- When defined:
  - Adds input mask_i, width N.
  - Selection uses pending & ~mask_i.
  - Masked pending bits stay set and are granted once unmasked.
  - Masking does not revoke a grant already in HOLD.
  - busy_o still counts masked pending bits.
- When undefined: no mask_i port and every pending bit is selectable. Behaviour is otherwise identical.

Test Plan:
- Reset release, N=8, RR=0, out_ready=1, req_i=8'b1010_0100 for one cycle: grants appear on consecutive cycles as out_code 2, 5, 7; out_valid then falls; pending_o=0, busy_o=0.
- Backpressure, N=8, RR=0, req_i=8'b0000_0011 pulse, out_ready=0 for 5 cycles: out_valid=1 and out_code=0 held stable throughout, pending_o=8'b0000_0010. Raise out_ready: next grant is code 1.
- Round-robin, N=8, RR=1, req_i=8'hFF held continuously, out_ready=1: out_code cycles 0,1,…,7,0,1… with no repeats and no bubbles.
- Same-edge set/clear, RR=0: pending[3] alone, req_i[3]=1 on the grant edge: code 3 is granted and pending_o[3] remains 1, giving a second grant of code 3 next.
- Reset mid-operation: with out_valid=1 and pending_o=8'h81, pulse rst_n low between edges: outputs clear asynchronously; after release there is no grant until a new request arrives.
- Mask build (N=6, RR=0): mask_i=6'b000001, req_i=6'b010001 pulse: code 4 granted first. Clear the mask: code 0 granted next. Also confirm out_code never exceeds 5.
